ir_cmd_ctrl: RTL
================

Name: ir_cmd_ctrl

Overview:
- Command controller between the IR receiver (32-bit frame + 1-cycle valid strobe) and downstream consumers (display, mode logic).
- Validates each frame: custom code match and command/inverted-command complement check.
- Suppresses auto-repeat of a held key within a time window, then queues accepted command bytes in a small FIFO with a valid/ready handshake.
- Keeps saturating error and overflow counters for debug display.

Parameters:
CUSTOM_CODE, 16'h00FF, required value of i_frame[31:16]
FIFO_DEPTH, 4, command FIFO entries (power of two, 2..16)
REPEAT_WIN, 32'd5_500_000, repeat-suppression window in clk cycles (110 ms at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
i_frame  input  32  frame: [31:16] custom code, [15:8] command, [7:0] inverted command
i_frame_vld  input  1  1-cycle strobe; i_frame is valid in the same cycle
i_flush  input  1  synchronous flush of FIFO and repeat history
o_cmd  output  8  FIFO head command byte
o_cmd_vld  output  1  FIFO not empty
i_cmd_rdy  input  1  consumer ready; pop when o_cmd_vld & i_cmd_rdy
o_fifo_cnt  output  5  current FIFO occupancy
o_err_cnt  output  8  bad-frame count, saturates at 255
o_ovf_cnt  output  8  dropped-good-frame count (FIFO full or busy), saturates at 255

Behaviour:
- Reset (rst_n=0, async): state=IDLE, FIFO empty, o_cmd=0, o_cmd_vld=0, o_fifo_cnt=0, o_err_cnt=0, o_ovf_cnt=0, repeat timer=0, last_vld=0, last_cmd=0. Reset mid-frame discards the frame; no partial FIFO write.
- FSM states: IDLE, CHECK, PUSH.
- IDLE: on i_frame_vld=1, capture i_frame into a frame register and go to CHECK; otherwise stay.
- CHECK (1 cycle), evaluated in this order:
  - custom != CUSTOM_CODE, or inv != ~cmd: o_err_cnt++ (saturating); go to IDLE.
  - last_vld=1 and cmd==last_cmd and timer!=0: repeat; reload timer=REPEAT_WIN, no write; go to IDLE.
  - otherwise: go to PUSH.
- PUSH (1 cycle):
  - FIFO has room (not full, or full with a pop in the same cycle): write cmd.
  - FIFO full with no pop: o_ovf_cnt++ and drop.
  - In both cases: last_cmd=cmd, last_vld=1, timer=REPEAT_WIN; go to IDLE.
- Latency: strobe sampled in IDLE at cycle N -> CHECK at N+1 -> PUSH at N+2 -> o_cmd_vld=1 and o_cmd valid from N+3 (FIFO previously empty).
- i_frame_vld in CHECK or PUSH: frame ignored, o_ovf_cnt++.
- Repeat timer: down-counter, decrements by 1 per cycle while nonzero, holds at 0; reload overrides decrement.
- FIFO: first-word-fall-through; o_cmd=head entry, 0 when empty.
  - Pop when empty: no effect.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH; o_fifo_cnt ranges 0..FIFO_DEPTH.
- i_flush=1: FIFO emptied, last_vld=0, timer=0 on the next edge; counters retained, FSM continues. Flush coincident with PUSH: flush wins, the write is discarded (not counted as overflow).
- All outputs registered except o_cmd_vld and o_cmd, which are decoded from FIFO registers.

Test Plan:
- Reset, then frame 0x00FF_45BA strobe at cycle N -> o_cmd=0x45, o_cmd_vld=1 at N+3, o_fifo_cnt=1; one pop with i_cmd_rdy=1 -> o_cmd_vld=0, o_fifo_cnt=0.
- Frames 0x00FF_45BB (bad complement) and 0x10EF_45BA (bad custom) -> no writes, o_err_cnt=2, o_ovf_cnt=0.
- REPEAT_WIN=100: frame 0x45 at t=0 and again at t=50 -> one entry only, timer reloaded; 0x45 again at t=200 -> second entry; 0x46 at t=210 -> accepted immediately, o_fifo_cnt=3.
- FIFO_DEPTH=4, i_cmd_rdy=0, six distinct valid commands spaced over 10 cycles -> o_fifo_cnt=4, o_ovf_cnt=2, FIFO head=first command; drain pops commands in arrival order.
- FIFO full, PUSH cycle coincident with pop -> new command written, o_fifo_cnt stays 4, o_ovf_cnt unchanged.
- Strobe at N and N+1 -> second frame dropped, o_ovf_cnt=1. Assert i_flush during a PUSH cycle -> FIFO empty, no write, o_ovf_cnt unchanged. Assert rst_n=0 while in CHECK -> all outputs 0 immediately.

Source files
------------

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: validates IR frames, suppresses auto-repeat and queues command bytes in a FWFT FIFO.
module ir_cmd_ctrl #(
  parameter logic [15:0] CUSTOM_CODE = 16'h00FF,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] REPEAT_WIN  = 32'd5_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_frame,
  input  logic        i_frame_vld,
  input  logic        i_flush,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  output logic [4:0]  o_fifo_cnt,
  output logic [7:0]  o_err_cnt,
  output logic [7:0]  o_ovf_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CHECK, PUSH} state_t;
  state_t          state_q;
  logic [31:0]     frame_q, timer_q;
  logic [7:0]      last_cmd_q, err_q, ovf_q;
  logic            last_vld_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [4:0]      cnt_q;
  logic [7:0]      cmd;
  logic            bad, rpt, full, pop, push, drop, busy;
  logic [8:0]      ovf_sum;
  assign cmd      = frame_q[15:8];
  assign bad      = frame_q[31:16] != CUSTOM_CODE || frame_q[7:0] != ~cmd;
  assign rpt      = last_vld_q && cmd == last_cmd_q && timer_q != 32'd0;
  assign full     = cnt_q == 5'(FIFO_DEPTH);
  assign pop      = cnt_q != 5'd0 && i_cmd_rdy;
  // a pop in the PUSH cycle frees the slot for the incoming write; flush discards the write
  assign push     = state_q == PUSH && !i_flush && (!full || pop);
  assign drop     = state_q == PUSH && !i_flush && full && !pop;
  assign busy     = state_q != IDLE && i_frame_vld;
  assign ovf_sum  = {1'b0, ovf_q} + 9'(drop) + 9'(busy);
  assign o_cmd_vld  = cnt_q != 5'd0;
  assign o_cmd      = o_cmd_vld ? mem_q[rd_q] : 8'd0;
  assign o_fifo_cnt = cnt_q;
  assign o_err_cnt  = err_q;
  assign o_ovf_cnt  = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= 32'd0;
      timer_q    <= 32'd0;
      last_cmd_q <= 8'd0;
      last_vld_q <= 1'b0;
      err_q      <= 8'd0;
      ovf_q      <= 8'd0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= 5'd0;
    end else begin
      ovf_q   <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
      timer_q <= timer_q != 32'd0 ? timer_q - 32'd1 : 32'd0;
      case (state_q)
        IDLE: if (i_frame_vld) begin
          frame_q <= i_frame;
          state_q <= CHECK;
        end
        CHECK: begin
          state_q <= (bad || rpt) ? IDLE : PUSH;
          if (bad) err_q <= err_q + 8'(err_q != 8'hFF);
          else if (rpt) timer_q <= REPEAT_WIN;
        end
        PUSH: begin
          last_cmd_q <= cmd;
          last_vld_q <= 1'b1;
          timer_q    <= REPEAT_WIN;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (i_flush) begin
        wr_q       <= '0;
        rd_q       <= '0;
        cnt_q      <= 5'd0;
        last_vld_q <= 1'b0;
        timer_q    <= 32'd0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + 5'(push) - 5'(pop);
      end
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= cmd;
endmodule
